// File: rtl/adder_event_conditioner.sv
// Event conditioner in front of the up-counter: synchronizes and debounces a raw
// event line, spaces the resulting inc pulses with a holdoff, and turns clr_req into clr.
module adder_event_conditioner #(
  parameter int  DEBOUNCE = 4,
  parameter int  HOLDOFF  = 2,
  localparam int DBW      = $clog2(DEBOUNCE + 1)
) (
  input  logic aclk,
  input  logic arstn,
  input  logic evt_in,
  input  logic en,
  input  logic clr_req,
  output logic inc,
  output logic clr,
  output logic busy,
  output logic drop
);

  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

  logic           s1_q, s2_q;
  logic           deb_q, deb_d;
  logic [DBW-1:0] dcnt_q, dcnt_d;
  state_t         state_q, state_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           pend_q, pend_d;
  logic           inc_q, inc_d;
  logic           drop_q, drop_d;
  logic           clr_q;
  logic           rise;
  logic           active;
  logic           pend_set;

  // NOTE: every sequential state uses <= so all flops sample pre-edge values together.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      deb_q   <= 1'b0;
      dcnt_q  <= '0;
      state_q <= IDLE;
      hold_q  <= '0;
      pend_q  <= 1'b0;
      inc_q   <= 1'b0;
      drop_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      s1_q    <= evt_in;
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      state_q <= state_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      inc_q   <= inc_d;
      drop_q  <= drop_d;
      clr_q   <= clr_req;
    end
  end

  // NOTE: defaults first in every always_comb so no path leaves a variable unassigned (no latches).
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    if (s2_q != deb_q) begin
      // The DEBOUNCE-th consecutive differing sample is the one that flips deb.
      if (dcnt_q == DBW'(DEBOUNCE - 1)) deb_d = s2_q;
      else                              dcnt_d = dcnt_q + 1'b1;
    end
  end

  assign rise     = deb_d & ~deb_q & en;
  assign active   = (state_q != IDLE);
  assign pend_set = rise & active & ~pend_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pend_d  = pend_q | pend_set;
    inc_d   = 1'b0;
    drop_d  = rise & active & pend_q;

    unique case (state_q)
      IDLE: begin
        if (rise) state_d = PULSE;
      end
      PULSE: begin
        inc_d = 1'b1;
        if (HOLDOFF == 0) begin
          if (pend_q || pend_set) begin
            state_d = PULSE;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = HOLD;
          hold_d  = HW'(HOLDOFF);
        end
      end
      HOLD: begin
        hold_d = hold_q - 1'b1;
        // Last holdoff cycle: a buffered (or just-arrived) event issues immediately.
        if (hold_q <= HW'(1)) begin
          if (pend_q || pend_set) begin
            state_d = PULSE;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear wins over everything in the pulse path; deb and its counter keep running.
    if (clr_req) begin
      state_d = IDLE;
      pend_d  = 1'b0;
      inc_d   = 1'b0;
    end
  end

  assign inc  = inc_q;
  assign clr  = clr_q;
  assign drop = drop_q;
  assign busy = active | pend_q;

endmodule
